servo_slew_limiter: RTL

SERVO_SLEW_LIMITER -- requirements
Module: servo_slew_limiter

---
 rtl/servo_pkg.sv | 15 +
 rtl/tick_watchdog.sv | 30 +++
 rtl/servo_slew_limiter.sv | 95 +++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared defaults and state encoding for the servo slew limiter.
package servo_pkg;

  localparam int POS_W      = 10;
  localparam int POS_MIN    = 0;
  localparam int POS_MAX    = 1000;
  localparam int POS_CENTER = 500;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_TRACK,
    ST_FAULT
  } slew_state_t;

endpackage

// File: rtl/tick_watchdog.sv
// Counts ticks while enabled and flags expiry after TIMEOUT_TICKS ticks without a kick.
module tick_watchdog #(
  parameter int TIMEOUT_TICKS = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic kick,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(TIMEOUT_TICKS));

  // The count holds at the limit, so expired stays high until the next kick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (kick) begin
      count <= '0;
    end else if (enable && tick && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/servo_slew_limiter.sv
// Rate-limits servo position toward a clamped target, with a tick watchdog that
// drops into failsafe (centre) when targets stop arriving.
module servo_slew_limiter #(
  parameter int POS_W         = servo_pkg::POS_W,
  parameter int POS_MIN       = servo_pkg::POS_MIN,
  parameter int POS_MAX       = servo_pkg::POS_MAX,
  parameter int POS_CENTER    = servo_pkg::POS_CENTER,
  parameter int MAX_STEP      = 4,
  parameter int TIMEOUT_TICKS = 250
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1khz,
  input  logic             target_valid,
  input  logic [POS_W-1:0] target,
  output logic [POS_W-1:0] pos,
  output logic             pos_stb,
  output logic             settled,
  output logic             fault
);

  import servo_pkg::*;

  slew_state_t      state, state_next;
  logic [POS_W-1:0] tgt, tgt_next;
  logic [POS_W-1:0] pos_next;
  logic             pos_move;
  logic             expired;
  logic signed [POS_W:0] diff;

  localparam logic signed [POS_W:0] STEP_S = (POS_W+1)'(MAX_STEP);
  localparam logic [POS_W-1:0]      STEP_U = POS_W'(MAX_STEP);

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] t);
    if (int'(t) < POS_MIN) return POS_W'(POS_MIN);
    if (int'(t) > POS_MAX) return POS_W'(POS_MAX);
    return t;
  endfunction

  tick_watchdog #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick_1khz),
    .kick   (target_valid),
    .enable (state == ST_TRACK),
    .expired(expired)
  );

  // One extra bit keeps the signed difference from wrapping at the range ends.
  assign diff = $signed({1'b0, tgt}) - $signed({1'b0, pos});

  always_comb begin
    pos_next = pos;
    pos_move = 1'b0;
    if (tick_1khz && (diff != '0)) begin
      pos_move = 1'b1;
      if (diff > STEP_S)       pos_next = pos + STEP_U;
      else if (diff < -STEP_S) pos_next = pos - STEP_U;
      else                     pos_next = tgt;
    end
  end

  always_comb begin
    state_next = state;
    tgt_next   = tgt;
    if (target_valid) begin
      state_next = ST_TRACK;
      tgt_next   = clamp_pos(target);
    end else if ((state == ST_TRACK) && expired) begin
      state_next = ST_FAULT;
      tgt_next   = POS_W'(POS_CENTER);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_INIT;
      tgt     <= POS_W'(POS_CENTER);
      pos     <= POS_W'(POS_CENTER);
      pos_stb <= 1'b0;
      settled <= 1'b1;
    end else begin
      state   <= state_next;
      tgt     <= tgt_next;
      pos     <= pos_next;
      pos_stb <= pos_move;
      settled <= (pos == tgt);
    end
  end

  assign fault = (state == ST_FAULT);

endmodule
